// File: rtl/rv32_pkg.sv
// Shared RV32 definitions for the M-extension multiply/divide datapath.
package rv32_pkg;

  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } muldiv_state_e;

  function automatic logic op_is_div(input muldiv_op_e op);
    return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
  endfunction

  function automatic logic op_is_rem(input muldiv_op_e op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/restoring_divider.sv
// Unsigned restoring divider, one quotient bit per cycle; o_done marks the final step,
// and o_quot/o_rem carry the values produced by the current step.
module restoring_divider #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic [DATA_WIDTH-1:0] i_dividend,
  input  logic [DATA_WIDTH-1:0] i_divisor,
  output logic                  o_done,
  output logic [DATA_WIDTH-1:0] o_quot,
  output logic [DATA_WIDTH-1:0] o_rem
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W);

  logic          r_busy;
  logic [CW-1:0] r_cnt;
  logic [W-1:0]  r_quot;
  logic [W-1:0]  r_rem;
  logic [W-1:0]  r_divisor;

  logic [W:0]    w_shift;
  logic [W:0]    w_diff;
  logic          w_ge;

  // The borrow out of the trial subtraction decides whether to restore.
  assign w_shift = {r_rem, r_quot[W-1]};
  assign w_diff  = w_shift - {1'b0, r_divisor};
  assign w_ge    = ~w_diff[W];
  assign o_quot  = {r_quot[W-2:0], w_ge};
  assign o_rem   = w_ge ? w_diff[W-1:0] : w_shift[W-1:0];
  assign o_done  = r_busy && (r_cnt == CW'(W - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy    <= 1'b0;
      r_cnt     <= '0;
      r_quot    <= '0;
      r_rem     <= '0;
      r_divisor <= '0;
    end else if (i_start) begin
      r_busy    <= 1'b1;
      r_cnt     <= '0;
      r_quot    <= i_dividend;
      r_rem     <= '0;
      r_divisor <= i_divisor;
    end else if (r_busy) begin
      r_quot <= o_quot;
      r_rem  <= o_rem;
      r_cnt  <= r_cnt + 1'b1;
      if (o_done) begin
        r_busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide with start/busy/done handshake and sign correction.
// Define MULDIV_FAST_MUL_EN to resolve all multiplies combinationally at acceptance.
module muldiv_unit
  import rv32_pkg::*;
#(
  parameter int DATA_WIDTH = XLEN
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [2:0]            funct3_i,
  input  logic [DATA_WIDTH-1:0] rs1_i,
  input  logic [DATA_WIDTH-1:0] rs2_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] result_o
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W);
  localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

  muldiv_state_e r_state;
  muldiv_state_e w_state_nxt;

  logic [CW-1:0]  r_cnt;
  muldiv_op_e     r_op;
  logic           r_neg_res;
  logic           r_neg_rem;
  logic [W-1:0]   r_mcand;
  logic [2*W-1:0] r_acc;
  logic [W-1:0]   r_result;

  muldiv_op_e     w_op;
  logic           w_accept;
  logic           w_is_div;
  logic           w_rs1_signed;
  logic           w_rs2_signed;
  logic           w_a_neg;
  logic           w_b_neg;
  logic [W-1:0]   w_a_mag;
  logic [W-1:0]   w_b_mag;
  logic           w_div0;
  logic           w_ovf;
  logic           w_special;
  logic [W-1:0]   w_special_res;

  logic [W:0]     w_sum;
  logic [2*W-1:0] w_acc_nxt;
  logic [2*W-1:0] w_prod;
  logic [W-1:0]   w_mul_res;
  logic           w_last;
  logic           w_calc_end;

  logic           w_div_start;
  logic           w_div_done;
  logic [W-1:0]   w_quot;
  logic [W-1:0]   w_rem;
  logic [W-1:0]   w_div_res;

  // Operand decode at the accepting edge: signs, magnitudes, special cases.
  assign w_op         = muldiv_op_e'(funct3_i);
  assign w_is_div     = op_is_div(w_op);
  assign w_accept     = start_i && (r_state != S_CALC);
  assign w_rs1_signed = (w_op == OP_MULH) || (w_op == OP_MULHSU) || (w_op == OP_DIV) || (w_op == OP_REM);
  assign w_rs2_signed = (w_op == OP_MULH) || (w_op == OP_DIV) || (w_op == OP_REM);
  assign w_a_neg      = w_rs1_signed && rs1_i[W-1];
  assign w_b_neg      = w_rs2_signed && rs2_i[W-1];
  assign w_a_mag      = w_a_neg ? (~rs1_i + 1'b1) : rs1_i;
  assign w_b_mag      = w_b_neg ? (~rs2_i + 1'b1) : rs2_i;
  assign w_div0       = w_is_div && (rs2_i == '0);
  assign w_ovf        = ((w_op == OP_DIV) || (w_op == OP_REM)) && (rs1_i == MIN_NEG) && (rs2_i == '1);

`ifdef MULDIV_FAST_MUL_EN
  logic signed [2*W-1:0] w_fa;
  logic signed [2*W-1:0] w_fb;
  logic [2*W-1:0]        w_fast_prod;

  assign w_fa        = {{W{w_a_neg}}, rs1_i};
  assign w_fb        = {{W{w_b_neg}}, rs2_i};
  assign w_fast_prod = w_fa * w_fb;
  assign w_special   = w_div0 || w_ovf || !w_is_div;
`else
  assign w_special   = w_div0 || w_ovf;
`endif

  always_comb begin
    w_special_res = '1;
    if (w_div0) begin
      w_special_res = op_is_rem(w_op) ? rs1_i : '1;
    end else if (w_ovf) begin
      w_special_res = op_is_rem(w_op) ? '0 : MIN_NEG;
    end
`ifdef MULDIV_FAST_MUL_EN
    else if (!w_is_div) begin
      w_special_res = (w_op == OP_MUL) ? w_fast_prod[W-1:0] : w_fast_prod[2*W-1:W];
    end
`endif
  end

  // Shift-add: multiplier sits in the low half and shifts out as the product shifts in.
  assign w_sum     = {1'b0, r_acc[2*W-1:W]} + (r_acc[0] ? {1'b0, r_mcand} : '0);
  assign w_acc_nxt = {w_sum, r_acc[W-1:1]};
  assign w_prod    = r_neg_res ? (~w_acc_nxt + 1'b1) : w_acc_nxt;
  assign w_mul_res = (r_op == OP_MUL) ? w_prod[W-1:0] : w_prod[2*W-1:W];

  assign w_div_start = w_accept && w_is_div && !w_special;
  assign w_div_res   = op_is_rem(r_op) ? (r_neg_rem ? (~w_rem + 1'b1) : w_rem)
                                       : (r_neg_res ? (~w_quot + 1'b1) : w_quot);

  assign w_last     = (r_cnt == CW'(W - 1));
  assign w_calc_end = op_is_div(r_op) ? w_div_done : w_last;

  restoring_divider #(
    .DATA_WIDTH(W)
  ) u_div (
    .clk       (clk),
    .rst       (rst),
    .i_start   (w_div_start),
    .i_dividend(w_a_mag),
    .i_divisor (w_b_mag),
    .o_done    (w_div_done),
    .o_quot    (w_quot),
    .o_rem     (w_rem)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    busy_o      = 1'b0;
    done_o      = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        done_o = (r_state == S_DONE);
        if (w_accept) begin
          w_state_nxt = w_special ? S_DONE : S_CALC;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_CALC: begin
        busy_o = 1'b1;
        if (w_calc_end) begin
          w_state_nxt = S_DONE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_op      <= OP_MUL;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_mcand   <= '0;
      r_acc     <= '0;
      r_result  <= '0;
    end else if (w_accept) begin
      r_cnt     <= '0;
      r_op      <= w_op;
      r_neg_res <= w_a_neg ^ w_b_neg;
      r_neg_rem <= w_a_neg;
      r_mcand   <= w_a_mag;
      r_acc     <= {{W{1'b0}}, w_b_mag};
      if (w_special) begin
        r_result <= w_special_res;
      end
    end else if (r_state == S_CALC) begin
      r_cnt <= r_cnt + 1'b1;
      r_acc <= w_acc_nxt;
      if (w_calc_end) begin
        r_result <= op_is_div(r_op) ? w_div_res : w_mul_res;
      end
    end
  end

  assign result_o = r_result;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: arithmetic reference model with cycle-level timing expectations,
// plus directed operations with hand-computed results.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_i = 1'b0;
  logic [2:0]  funct3_i = 3'd0;
  logic [31:0] rs1_i = 32'd0;
  logic [31:0] rs2_i = 32'd0;
  logic        busy_o;
  logic        done_o;
  logic [31:0] result_o;

  muldiv_unit #(.DATA_WIDTH(32)) dut (
    .clk     (clk),
    .rst     (rst),
    .start_i (start_i),
    .funct3_i(funct3_i),
    .rs1_i   (rs1_i),
    .rs2_i   (rs2_i),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .result_o(result_o)
  );

  always #5 clk = ~clk;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 0;
`else
  localparam int MUL_LAT = 32;
`endif

  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  bit          chk_en = 1'b0;
  int          m_left = 0;
  bit          m_done = 1'b0;
  logic [31:0] m_result = 32'd0;
  logic [31:0] m_pend = 32'd0;

  function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, ua, ub;
    logic [63:0] p;
    bit          ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = longint'({32'd0, a});
    ub  = longint'({32'd0, b});
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p   = 64'd0;
    case (f)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        p = ua / ub; return p[31:0];
      end
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        p = ua % ub; return p[31:0];
      end
    endcase
  endfunction

  function automatic bit ref_fast(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2]) return (b == 0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
`ifdef MULDIV_FAST_MUL_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference timing: accepted ops finish 32 edges later, or at the accepting edge if resolved early.
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_left   = 0;
      m_done   = 1'b0;
      m_result = 32'd0;
    end else begin
      m_done = 1'b0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_done   = 1'b1;
          m_result = m_pend;
        end
      end else if (start_i) begin
        m_pend = ref_result(funct3_i, rs1_i, rs2_i);
        if (ref_fast(funct3_i, rs1_i, rs2_i)) begin
          m_done   = 1'b1;
          m_result = m_pend;
        end else begin
          m_left = 32;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy_o", 32'(busy_o), 32'(m_left > 0));
      check("done_o", 32'(done_o), 32'(m_done));
      check("result_o", result_o, m_result);
    end
  end

  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, output int acc);
    start_i  = 1'b1;
    funct3_i = f;
    rs1_i    = a;
    rs2_i    = b;
    @(posedge clk);
    #1;
    acc = cyc;
  endtask

  task automatic wait_done(input int acc, input int poke, input logic [31:0] exp, input int lat,
                           input string nm, output int gaps);
    bit seen;
    seen = 1'b0;
    gaps = 0;
    @(negedge clk);
    start_i  = 1'b0;
    funct3_i = 3'($urandom);
    rs1_i    = $urandom;
    rs2_i    = $urandom;
    for (int k = 0; k < 40; k++) begin
      if (done_o) begin
        seen = 1'b1;
        break;
      end
      if (!busy_o) gaps++;
      start_i = (k == poke);
      @(negedge clk);
    end
    start_i = 1'b0;
    check({nm, " done seen"}, 32'(seen), 32'd1);
    if (seen) begin
      check({nm, " result"}, result_o, exp);
      check({nm, " latency"}, 32'(cyc - acc), 32'(lat));
    end
  endtask

  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int lat, input string nm);
    int acc, gaps;
    @(negedge clk);
    issue(f, a, b, acc);
    wait_done(acc, -1, exp, lat, nm, gaps);
  endtask

  initial begin
    int acc, gaps, n_done;
    rst = 1'b1;
    @(posedge clk);
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    check("reset busy", 32'(busy_o), 32'd0);
    check("reset done", 32'(done_o), 32'd0);
    check("reset result", result_o, 32'd0);
    rst = 1'b0;

    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT, "MUL 7*-3");
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MUL_LAT, "MULH min*min");
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT, "MULHU max*max");
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT, "MULHSU -1*max");
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32, "DIV -7/2");
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32, "REM -7/2");
    run_op(3'd5, 32'd100, 32'd7, 32'd14, 32, "DIVU 100/7");
    run_op(3'd7, 32'd100, 32'd7, 32'd2, 32, "REMU 100/7");
    run_op(3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF, 0, "DIV 5/0");
    run_op(3'd6, 32'd5, 32'd0, 32'd5, 0, "REM 5/0");
    run_op(3'd5, 32'd9, 32'd0, 32'hFFFF_FFFF, 0, "DIVU 9/0");
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, "DIV ovf");
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0, "REM ovf");
    run_op(3'd4, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32, "DIV 7/-2");

    // A start during CALC is dropped and must not disturb the running divide.
    @(negedge clk);
    issue(3'd5, 32'd1000, 32'd3, acc);
    wait_done(acc, 4, 32'd333, 32, "ignored start", gaps);

    // Reset in the middle of an operation aborts it with no completion.
    @(negedge clk);
    issue(3'd5, 32'd1000, 32'd3, acc);
    @(negedge clk);
    start_i = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort busy", 32'(busy_o), 32'd0);
    check("abort result", result_o, 32'd0);
    n_done = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done_o) n_done++;
    end
    check("abort no done", 32'(n_done), 32'd0);

    // Back-to-back: the second start lands in the DONE cycle of the first.
    @(negedge clk);
    issue(3'd5, 32'd100, 32'd7, acc);
    wait_done(acc, -1, 32'd14, 32, "b2b first", gaps);
    issue(3'd5, 32'hFFFF_FFFF, 32'd16, acc);
    wait_done(acc, -1, 32'h0FFF_FFFF, 32, "b2b second", gaps);
    check("b2b busy gaps", 32'(gaps), 32'd0);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide unit sitting directly downstream of the register file. It takes the two register-read operands (rs1/rs2 data) plus the M-extension `funct3` and computes the 32-bit result over multiple cycles. It signals completion to the writeback path with a start/busy/done handshake. The core holds its PC while `busy_o` is high.

## Interface
Parameters:
- DATA_WIDTH, 32: operand/result width; iteration count equals DATA_WIDTH.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  reset; synchronous and active-high; has priority over every other input.
- start_i  in  1  request; accepted only on an edge where `busy_o`=0.
- funct3_i  in  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- rs1_i  in  DATA_WIDTH  operand A (dividend or multiplicand).
- rs2_i  in  DATA_WIDTH  operand B (divisor or multiplier).
- busy_o  out  1  high while in CALC.
- done_o  out  1  one-cycle pulse; `result_o` is valid in that cycle.
- result_o  out  DATA_WIDTH  result; held until the next completion or reset.

## Operation
States:
- IDLE: `busy_o`=0, `done_o`=0.
- CALC: `busy_o`=1.
- DONE: `done_o`=1, `busy_o`=0.

Transitions:
- IDLE/DONE + accepted start → CALC. The bit counter is cleared.
- Special cases go directly → DONE instead (see below).
- DONE without start → IDLE.
- CALC with counter == DATA_WIDTH-1 → DONE.

Operand handling:
- `funct3_i`, `rs1_i` and `rs2_i` are latched at the accepting edge. Input changes afterwards are ignored.
- Signed ops (MULH, DIV, REM, and rs1 only for MULHSU) operate on magnitudes. The sign is corrected at the end.
  - The 2×DATA_WIDTH product is negated if the operand signs differ.
  - The quotient is negated if the signs differ.
  - The remainder takes the sign of the dividend.
- Multiply:
  - Shift-add, one multiplier bit per CALC cycle, into a 2×DATA_WIDTH accumulator.
  - MUL returns the low half.
  - MULH, MULHSU and MULHU return the high half.
- Divide:
  - Restoring, one quotient bit per CALC cycle.
  - DIV/DIVU return the quotient; REM/REMU return the remainder.

Special cases (resolved at acceptance, no CALC):
- Divisor 0: DIV/DIVU → all ones; REM/REMU → rs1.
- DIV with 0x80000000 / 0xFFFFFFFF → 0x80000000; REM with the same operands → 0.

Start while `busy_o`=1 is ignored and dropped, not queued.

## Timing
- Edge 0 is the accepting edge.
- Iterative ops:
  - CALC runs during edges 1..DATA_WIDTH.
  - `result_o` is registered and the state enters DONE at edge DATA_WIDTH (32).
  - `done_o` is high for the cycle between edges 32 and 33.
- Special cases, and fast multiply: DONE is entered at edge 0; `done_o` is high in the following cycle.
- Back-to-back: a start sampled in the DONE cycle is accepted.
- Reset:
  - `rst` at any edge forces IDLE, `busy_o`=0, `done_o`=0, `result_o`=0 and counter=0.
  - Mid-CALC reset aborts the operation with no done pulse.

## Configuration
- MULDIV_FAST_MUL_EN defined:
  - MUL/MULH/MULHSU/MULHU use a combinational 33×33 signed multiply.
  - They complete like special cases, with DONE at edge 0.
  - Divides are unchanged.
- MULDIV_FAST_MUL_EN undefined: multiplies use the 32-cycle shift-add path described above.

## Structure
- Shared package `rv32_pkg` holds:
  - XLEN = 32
  - the `muldiv_op_e` enum (funct3 encodings above)
  - the `muldiv_state_e` enum (IDLE, CALC, DONE)
- Natural sub-module: `restoring_divider`.
  - Unsigned magnitude divider: start in, done out.
  - Instantiated by `muldiv_unit`, which owns the sign handling and special cases.

## Test plan
- MUL, 7 × 0xFFFFFFFD → result 0xFFFFFFEB. `done_o` 32 cycles after accept (1 cycle with MULDIV_FAST_MUL_EN).
- MULH 0x80000000 × 0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD; REM of the same → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2.
- DIV 5/0 → 0xFFFFFFFF and REM 5/0 → 5, each done 1 cycle after accept. DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM → 0.
- Start pulsed at CALC cycle 5 with new operands → ignored; the first result is unaffected.
  - `rst` at CALC cycle 10 → `busy_o`=0 and `result_o`=0 next cycle.
  - No `done_o` for the aborted operation.
- Start asserted in the DONE cycle → accepted; the second result is correct 32 cycles later and `busy_o` never drops to a stale IDLE in between.
